// File: rtl/alu_issue.sv
//------------------------------------------------------------------------------
// Module      : alu_issue
// Description : Decodes one MIPS ALU instruction and issues it to an external
//               ALU. Captures the result behind a valid/ready handshake.
//               Optional macro ALU_ISSUE_STICKY_EXC_EN adds a sticky
//               exception flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [15:0] imm,
    input  logic [4:0]  dst,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  ins,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_dst,
    output logic        res_zero,
    output logic        res_we,
    output logic        exc_ovf,
    output logic        illegal,
    output logic        exc_sticky,
    input  logic        clr_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      r_state, w_state_nx;
    logic        w_accept;
    logic [3:0]  w_op;
    logic [1:0]  w_ins;
    logic [31:0] w_a, w_b;
    logic        w_ill;
    logic [31:0] w_sext, w_zext;

    logic [31:0] r_alu_a, r_alu_b;
    logic [3:0]  r_alu_op;
    logic [1:0]  r_ins;
    logic [4:0]  r_dst_lat;
    logic        r_ill_lat;

    assign w_sext = {{16{imm[15]}}, imm};
    assign w_zext = {16'h0000, imm};

    always_comb begin
        w_op  = 4'd0;
        w_ins = 2'b00;
        w_a   = rs_data;
        w_b   = rt_data;
        w_ill = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin w_op = 4'd1; w_ins = 2'b01; end
                    6'h21: w_op = 4'd1;
                    6'h22: begin w_op = 4'd2; w_ins = 2'b10; end
                    6'h23: w_op = 4'd2;
                    6'h24: w_op = 4'd3;
                    6'h25: w_op = 4'd4;
                    6'h26: w_op = 4'd5;
                    6'h27: w_op = 4'd6;
                    6'h2A: w_op = 4'd8;
                    6'h2B: w_op = 4'd7;
                    default: w_ill = 1'b1;
                endcase
            end
            6'h08: begin w_op = 4'd1; w_ins = 2'b01; w_b = w_sext; end
            6'h09: begin w_op = 4'd1; w_b = w_sext; end
            6'h0A: begin w_op = 4'd8; w_b = w_sext; end
            6'h0B: begin w_op = 4'd7; w_b = w_sext; end
            6'h0C: begin w_op = 4'd3; w_b = w_zext; end
            6'h0D: begin w_op = 4'd4; w_b = w_zext; end
            6'h0E: begin w_op = 4'd5; w_b = w_zext; end
            6'h0F: begin w_op = 4'd4; w_a = 32'h0; w_b = {imm, 16'h0000}; end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nx = EXEC;
            end
            EXEC: w_state_nx = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) w_state_nx = in_valid ? EXEC : IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    // Issue registers only change on an accept, so the ALU sees stable
    // operands for the whole EXEC/HOLD window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= 32'h0;
            r_alu_b   <= 32'h0;
            r_alu_op  <= 4'd0;
            r_ins     <= 2'b00;
            r_dst_lat <= 5'd0;
            r_ill_lat <= 1'b0;
        end else if (w_accept) begin
            r_alu_a   <= w_a;
            r_alu_b   <= w_b;
            r_alu_op  <= w_op;
            r_ins     <= w_ins;
            r_dst_lat <= dst;
            r_ill_lat <= w_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data <= 32'h0;
            res_dst  <= 5'd0;
            res_zero <= 1'b0;
            res_we   <= 1'b0;
            exc_ovf  <= 1'b0;
            illegal  <= 1'b0;
        end else if (r_state == EXEC) begin
            res_data <= alu_out;
            res_dst  <= r_dst_lat;
            res_zero <= alu_zero;
            exc_ovf  <= alu_ovf;
            illegal  <= r_ill_lat;
            res_we   <= ~r_ill_lat & ~alu_ovf & (r_dst_lat != 5'd0);
        end
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign ins    = r_ins;

`ifdef ALU_ISSUE_STICKY_EXC_EN
    logic r_exc_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_exc_sticky <= 1'b0;
        else if ((r_state == EXEC) && (alu_ovf || r_ill_lat))
            r_exc_sticky <= 1'b1;
        else if (clr_sticky)
            r_exc_sticky <= 1'b0;
    end

    assign exc_sticky = r_exc_sticky;
`else
    assign exc_sticky = clr_sticky & 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_issue
// Description : Directed self-checking bench for alu_issue with a small ALU model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue;

`ifdef ALU_ISSUE_STICKY_EXC_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic [4:0]  dst;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [1:0]  ins;
    logic [31:0] alu_out;
    logic        alu_zero, alu_ovf;
    logic        out_valid, out_ready;
    logic [31:0] res_data;
    logic [4:0]  res_dst;
    logic        res_zero, res_we, exc_ovf, illegal;
    logic        exc_sticky, clr_sticky;
    logic        force_ovf;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Reference ALU; overflow is injected by the bench.
    always_comb begin
        case (alu_op)
            4'd1:    alu_out = alu_a + alu_b;
            4'd2:    alu_out = alu_a - alu_b;
            4'd3:    alu_out = alu_a & alu_b;
            4'd4:    alu_out = alu_a | alu_b;
            4'd5:    alu_out = alu_a ^ alu_b;
            4'd6:    alu_out = ~(alu_a | alu_b);
            4'd7:    alu_out = {31'h0, alu_a < alu_b};
            4'd8:    alu_out = {31'h0, $signed(alu_a) < $signed(alu_b)};
            default: alu_out = 32'h0;
        endcase
    end
    assign alu_zero = (alu_out == 32'h0);
    assign alu_ovf  = force_ovf;

    alu_issue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct      (funct),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .dst        (dst),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .ins        (ins),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero),
        .alu_ovf    (alu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .res_data   (res_data),
        .res_dst    (res_dst),
        .res_zero   (res_zero),
        .res_we     (res_we),
        .exc_ovf    (exc_ovf),
        .illegal    (illegal),
        .exc_sticky (exc_sticky),
        .clr_sticky (clr_sticky)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [15:0] im, input logic [4:0] d);
        opcode = op; funct = fn; rs_data = rs; rt_data = rt; imm = im; dst = d;
        in_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct = '0; rs_data = '0;
        rt_data = '0; imm = '0; dst = '0; out_ready = 1'b0; clr_sticky = 1'b0;
        force_ovf = 1'b0;
        step(); step();
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_res_data", res_data, 32'h0);
        check("rst_res_flags", {26'h0, res_we, res_zero, exc_ovf, illegal, exc_sticky, 1'b0}, 32'h0);
        check("rst_res_dst", {27'h0, res_dst}, 32'h0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_op_ins", {26'h0, alu_op, ins}, 32'h0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // add rs=5 rt=7 dst=3
        drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0, 5'd3);
        step();
        in_valid = 1'b0;
        check("add_alu_op", {28'h0, alu_op}, 32'd1);
        check("add_ins", {30'h0, ins}, 32'b01);
        check("add_alu_b", alu_b, 32'd7);
        check("add_exec_out_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("add_out_valid", {31'h0, out_valid}, 32'h1);
        check("add_res_data", res_data, 32'd12);
        check("add_res_we", {31'h0, res_we}, 32'h1);
        check("add_res_zero", {31'h0, res_zero}, 32'h0);
        check("add_res_dst", {27'h0, res_dst}, 32'd3);
        out_ready = 1'b1;
        step();
        check("add_idle_out_valid", {31'h0, out_valid}, 32'h0);

        // ori then lui back-to-back
        drive(6'h0D, 6'h00, 32'd1, 32'hDEAD_BEEF, 16'h8000, 5'd4);
        step();
        in_valid = 1'b0;
        check("ori_alu_b", alu_b, 32'h0000_8000);
        check("ori_alu_op", {28'h0, alu_op}, 32'd4);
        step();
        check("ori_res_data", res_data, 32'h0000_8001);
        drive(6'h0F, 6'h00, 32'h5555_5555, 32'h0, 16'h1234, 5'd5);
        step();
        in_valid = 1'b0;
        check("lui_b2b_accept_exec", {31'h0, out_valid}, 32'h0);
        check("lui_alu_a", alu_a, 32'h0);
        check("lui_alu_b", alu_b, 32'h1234_0000);
        check("lui_alu_op", {28'h0, alu_op}, 32'd4);
        step();
        check("lui_res_data", res_data, 32'h1234_0000);
        step();

        // sub with overflow
        drive(6'h00, 6'h22, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 16'h0, 5'd5);
        force_ovf = 1'b1;
        step();
        in_valid = 1'b0;
        check("sub_op_ins", {26'h0, alu_op, ins}, {26'h0, 4'd2, 2'b10});
        step();
        force_ovf = 1'b0;
        check("sub_res_data", res_data, 32'h8000_0000);
        check("sub_exc_ovf", {31'h0, exc_ovf}, 32'h1);
        check("sub_res_we", {31'h0, res_we}, 32'h0);
        check("sub_sticky", {31'h0, exc_sticky}, {31'h0, STICKY_ON});
        step();
        check("sticky_held", {31'h0, exc_sticky}, {31'h0, STICKY_ON});
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_cleared", {31'h0, exc_sticky}, 32'h0);

        // backpressure: addu stalls in HOLD while 'and' waits upstream
        out_ready = 1'b0;
        drive(6'h00, 6'h21, 32'd10, 32'd20, 16'h0, 5'd6);
        step();
        drive(6'h00, 6'h24, 32'h0000_F0F0, 32'h0000_FF00, 16'h0, 5'd7);
        check("exec_in_ready", {31'h0, in_ready}, 32'h0);
        step();
        check("stall_alu_a_kept", alu_a, 32'd10);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_in_ready", {31'h0, in_ready}, 32'h0);
            check("stall_res_data", res_data, 32'd30);
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        check("and_alu_op", {28'h0, alu_op}, 32'd3);
        check("and_alu_a", alu_a, 32'h0000_F0F0);
        check("and_exec_out_valid", {31'h0, out_valid}, 32'h0);
        step();
        check("and_out_valid", {31'h0, out_valid}, 32'h1);
        check("and_res_data", res_data, 32'h0000_F000);
        check("and_res_dst", {27'h0, res_dst}, 32'd7);
        step();

        // reset during EXEC
        drive(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd8);
        step();
        in_valid = 1'b0;
        check("slt_alu_op", {28'h0, alu_op}, 32'd8);
        #1 rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'h0, out_valid}, 32'h0);
        check("arst_alu_op", {28'h0, alu_op}, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_out_valid0", {31'h0, out_valid}, 32'h0);
        step();
        check("post_rst_out_valid1", {31'h0, out_valid}, 32'h0);
        check("post_rst_res_data", res_data, 32'h0);

        // illegal opcode
        drive(6'h3F, 6'h00, 32'd1, 32'd2, 16'h0, 5'd9);
        step();
        in_valid = 1'b0;
        check("ill_op_ins", {26'h0, alu_op, ins}, 32'h0);
        step();
        check("ill_out_valid", {31'h0, out_valid}, 32'h1);
        check("ill_illegal", {31'h0, illegal}, 32'h1);
        check("ill_res_we", {31'h0, res_we}, 32'h0);
        check("ill_sticky", {31'h0, exc_sticky}, {31'h0, STICKY_ON});
        step();
        check("ill_done", {31'h0, out_valid}, 32'h0);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;

        // addiu with sign-extended imm to r0
        drive(6'h09, 6'h00, 32'd3, 32'h0, 16'hFFFF, 5'd0);
        step();
        in_valid = 1'b0;
        check("addiu_alu_b", alu_b, 32'hFFFF_FFFF);
        check("addiu_op_ins", {26'h0, alu_op, ins}, {26'h0, 4'd1, 2'b00});
        step();
        check("addiu_res_data", res_data, 32'd2);
        check("addiu_r0_res_we", {31'h0, res_we}, 32'h0);
        check("addiu_illegal", {31'h0, illegal}, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
